i2s_rx: RTL and testbench
=========================

Name: i2s_rx

Overview:
- I2S slave receiver: deserializes a standard-format I2S stream (BCLK, LRCLK, SDATA) into parallel left/right PCM words.
- Direct downstream counterpart of the I2S master transmitter. It is used for loopback verification of the tx path and for capturing codec ADC output.
- All interface inputs are oversampled in the system clock domain; the block generates no clocks.
- One frame = left word (LRCLK low) then right word (LRCLK high), MSB first, MSB one BCLK after the LRCLK edge.

Parameters:
- DATA_W, 16, bits per channel word; also the required BCLK count per LRCLK half-period.
- SYNC_STAGES, 2, flip-flop synchronizer depth on audio_bclk, audio_lrclk and audio_sdata (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 4x the BCLK frequency (nominal 12.288 MHz, BCLK = clk/8).
- rst  in  1  synchronous active-high reset.
- audio_bclk  in  1  I2S bit clock; data is sampled on its rising edge.
- audio_lrclk  in  1  word select; 0 = left, 1 = right.
- audio_sdata  in  1  serial data; transmitter changes it on the BCLK falling edge.
- audio_ldata  out  DATA_W  last complete left sample.
- audio_rdata  out  DATA_W  last complete right sample.
- sample_valid  out  1  one-clk pulse when audio_ldata and audio_rdata have been updated as a pair.
- frame_err  out  1  one-clk pulse when a word with a wrong bit count is discarded.

Behaviour:
- Reset (synchronous): audio_ldata = 0, audio_rdata = 0, sample_valid = 0, frame_err = 0. Synchronizers and shift register are cleared, bit counter = 0, state = WAIT_SYNC, left_ok = 0, and the lrclk history is invalidated.
- Edge detect: bclk_rise is asserted when the synced bclk is 1 and its previous value was 0. The block does nothing on clk cycles without bclk_rise.
- On each bclk_rise:
  - Sample s = synced sdata and w = synced lrclk.
  - Shift s into the LSB of the shift register (MSB first in time).
  - boundary = (w != w_prev). On the first bclk_rise after reset, w_prev is loaded from w and no boundary is detected.
  - The bit sampled on a boundary edge is the LSB of the word belonging to channel w_prev.
- States:
  - WAIT_SYNC: shift and count bits but discard them. On a boundary, clear the bit counter, clear left_ok and go to RUN. No frame_err is raised, because the first word is partial by definition.
  - RUN, non-boundary edge: bit counter += 1, saturating at DATA_W+1.
  - RUN, boundary edge, counted bits including this edge == DATA_W:
    - If w_prev = 0: copy the word to the left hold register and set left_ok = 1.
    - If w_prev = 1 and left_ok = 1: load audio_ldata from the left hold register and audio_rdata from the word in the same clk, pulse sample_valid, then clear left_ok.
    - If w_prev = 1 and left_ok = 0: discard the word silently.
  - RUN, boundary edge, count != DATA_W: discard the word, pulse frame_err, clear left_ok, remain in RUN. The counter restarts for the next word.
- Latency: sample_valid rises SYNC_STAGES+2 clk cycles after the audio_bclk rising edge that carries the right-channel LSB. Outputs are registered and hold their value between updates.
- Stalled BCLK: no edges, so no state change; outputs hold indefinitely.
- A reset asserted mid-word drops all partial data. The first sample_valid after reset follows one full discarded-or-partial word plus one complete L/R frame.
- An LRCLK glitch shorter than one BCLK period is invisible, because lrclk is sampled only on bclk_rise.

Test Plan:
- Drive a master-format stream (BCLK = clk/8, 16 BCLK per half-frame) with L = 16'hA5C3, R = 16'h5A3C for 4 frames. Required: audio_ldata = A5C3 and audio_rdata = 5A3C; sample_valid pulses exactly once per 256 clk from the second frame on; frame_err never asserts.
- Boundary-bit check with L = 16'h0001, R = 16'h8000. Required: exact capture, which proves the LSB is taken on the LRCLK-change edge and the MSB one BCLK later.
- Toggle LRCLK after 12 BCLKs in one left half-frame. Required: a single 1-clk frame_err pulse; no sample_valid for that frame; outputs keep their previous values; the next good frame restores valid pulses.
- Assert rst for 3 clk in the middle of a right word. Required: outputs = 0 immediately; no frame_err; the first valid pair (L = 8000, R = 7FFF) appears after the next complete frame.
- Hold audio_bclk at 0 for 1000 clk mid-frame, then resume. Required: no pulses and outputs unchanged while stopped; capture resumes correctly, with a frame_err only if the word bit count was broken.
- Sweep L = FFFF/R = 0000, then L = 0000/R = FFFF, back-to-back. Required: exact values; sample_valid fires once per frame.

Source files
------------

// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples BCLK/LRCLK/SDATA in the clk domain and
// assembles standard-format left/right words into a registered PCM pair.
module i2s_rx #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              audio_bclk,
    input  logic              audio_lrclk,
    input  logic              audio_sdata,
    output logic [DATA_W-1:0] audio_ldata,
    output logic [DATA_W-1:0] audio_rdata,
    output logic              sample_valid,
    output logic              frame_err
);
    localparam int CNT_W = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W + 1);
    // count held when the final (boundary) edge of a correct word arrives
    localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(DATA_W - 1);

    typedef enum logic [0:0] {
        WAIT_SYNC = 1'b0,
        RUN       = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
    logic [SYNC_STAGES-1:0] lrclk_sync_q, lrclk_sync_d;
    logic [SYNC_STAGES-1:0] sdata_sync_q, sdata_sync_d;
    logic                   bclk_prev_q, bclk_prev_d;
    logic                   rise_q, rise_d;
    logic                   s_q, s_d;
    logic                   w_q, w_d;
    logic                   w_prev_q, w_prev_d;
    logic                   w_prev_vld_q, w_prev_vld_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   left_ok_q, left_ok_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic [DATA_W-1:0]      left_hold_q, left_hold_d;
    logic [DATA_W-1:0]      ldata_q, ldata_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;

    logic [DATA_W-1:0]      word_s;
    logic                   boundary_s;
    logic [CNT_W-1:0]       cnt_inc_s;

    // Synchronizers and a one-cycle capture of the sampled bit at each BCLK rise
    always_comb begin
        bclk_sync_d  = {bclk_sync_q[SYNC_STAGES-2:0], audio_bclk};
        lrclk_sync_d = {lrclk_sync_q[SYNC_STAGES-2:0], audio_lrclk};
        sdata_sync_d = {sdata_sync_q[SYNC_STAGES-2:0], audio_sdata};
        bclk_prev_d  = bclk_sync_q[SYNC_STAGES-1];
        rise_d       = bclk_sync_q[SYNC_STAGES-1] & ~bclk_prev_q;
        s_d          = sdata_sync_q[SYNC_STAGES-1];
        w_d          = lrclk_sync_q[SYNC_STAGES-1];
    end

    // Word assembly, framing state machine and output update
    always_comb begin
        word_s       = {shift_q[DATA_W-2:0], s_q};
        boundary_s   = w_prev_vld_q && (w_q != w_prev_q);
        cnt_inc_s    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        w_prev_d     = w_prev_q;
        w_prev_vld_d = w_prev_vld_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        left_ok_d    = left_ok_q;
        shift_d      = shift_q;
        left_hold_d  = left_hold_q;
        ldata_d      = ldata_q;
        rdata_d      = rdata_q;
        valid_d      = 1'b0;
        err_d        = 1'b0;
        if (rise_q) begin
            shift_d      = word_s;
            w_prev_d     = w_q;
            w_prev_vld_d = 1'b1;
            case (state_q)
                WAIT_SYNC: begin
                    if (boundary_s) begin
                        cnt_d     = {CNT_W{1'b0}};
                        left_ok_d = 1'b0;
                        state_d   = RUN;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                RUN: begin
                    if (!boundary_s) begin
                        cnt_d = cnt_inc_s;
                    end else begin
                        // the boundary edge carries the LSB of the w_prev channel word
                        cnt_d = {CNT_W{1'b0}};
                        if (cnt_q == CNT_WORD) begin
                            if (!w_prev_q) begin
                                left_hold_d = word_s;
                                left_ok_d   = 1'b1;
                            end else if (left_ok_q) begin
                                ldata_d   = left_hold_q;
                                rdata_d   = word_s;
                                valid_d   = 1'b1;
                                left_ok_d = 1'b0;
                            end else begin
                                left_ok_d = 1'b0;
                            end
                        end else begin
                            err_d     = 1'b1;
                            left_ok_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = WAIT_SYNC;
                end
            endcase
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            bclk_sync_q  <= {SYNC_STAGES{1'b0}};
            lrclk_sync_q <= {SYNC_STAGES{1'b0}};
            sdata_sync_q <= {SYNC_STAGES{1'b0}};
            bclk_prev_q  <= 1'b0;
            rise_q       <= 1'b0;
            s_q          <= 1'b0;
            w_q          <= 1'b0;
            w_prev_q     <= 1'b0;
            w_prev_vld_q <= 1'b0;
            state_q      <= WAIT_SYNC;
            cnt_q        <= {CNT_W{1'b0}};
            left_ok_q    <= 1'b0;
            shift_q      <= {DATA_W{1'b0}};
            left_hold_q  <= {DATA_W{1'b0}};
            ldata_q      <= {DATA_W{1'b0}};
            rdata_q      <= {DATA_W{1'b0}};
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            bclk_sync_q  <= bclk_sync_d;
            lrclk_sync_q <= lrclk_sync_d;
            sdata_sync_q <= sdata_sync_d;
            bclk_prev_q  <= bclk_prev_d;
            rise_q       <= rise_d;
            s_q          <= s_d;
            w_q          <= w_d;
            w_prev_q     <= w_prev_d;
            w_prev_vld_q <= w_prev_vld_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            left_ok_q    <= left_ok_d;
            shift_q      <= shift_d;
            left_hold_q  <= left_hold_d;
            ldata_q      <= ldata_d;
            rdata_q      <= rdata_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
        end
    end

    assign audio_ldata  = ldata_q;
    assign audio_rdata  = rdata_q;
    assign sample_valid = valid_q;
    assign frame_err    = err_q;
endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: a continuous master-format stream (BCLK = clk/8,
// 16 BCLK per half) with a short word, a BCLK stall and a mid-word reset.
module tb_i2s_rx;
    localparam int DATA_W = 16;

    logic              clk;
    logic              rst;
    logic              audio_bclk;
    logic              audio_lrclk;
    logic              audio_sdata;
    logic [DATA_W-1:0] audio_ldata;
    logic [DATA_W-1:0] audio_rdata;
    logic              sample_valid;
    logic              frame_err;

    int checks;
    int errors;
    int valid_cnt;
    int err_cnt;
    int cyc;
    int prev_cyc;
    int last_interval;
    bit have_prev;
    logic pending;

    i2s_rx #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .audio_bclk   (audio_bclk),
        .audio_lrclk  (audio_lrclk),
        .audio_sdata  (audio_sdata),
        .audio_ldata  (audio_ldata),
        .audio_rdata  (audio_rdata),
        .sample_valid (sample_valid),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling clk edge
    always @(negedge clk) begin
        if (sample_valid === 1'b1) begin
            if (have_prev) last_interval = cyc - prev_cyc;
            prev_cyc  = cyc;
            have_prev = 1'b1;
            valid_cnt = valid_cnt + 1;
        end
        if (frame_err === 1'b1) err_cnt = err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit index i of a half-frame: i == 0 carries the previous word's LSB.
    task automatic send_bits(input logic lr, input logic [DATA_W-1:0] word,
                             input int first, input int last);
        for (int i = first; i <= last; i++) begin
            audio_bclk  = 1'b0;
            audio_lrclk = lr;
            audio_sdata = (i == 0) ? pending : word[DATA_W-i];
            repeat (4) @(negedge clk);
            audio_bclk = 1'b1;
            repeat (4) @(negedge clk);
        end
        pending = word[DATA_W-1-last];
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        send_bits(1'b0, l, 0, DATA_W-1);
        send_bits(1'b1, r, 0, DATA_W-1);
    endtask

    initial begin
        checks = 0; errors = 0; valid_cnt = 0; err_cnt = 0;
        cyc = 0; prev_cyc = 0; last_interval = 0; have_prev = 1'b0;
        pending = 1'b0;
        rst = 1'b1; audio_bclk = 1'b0; audio_lrclk = 1'b0; audio_sdata = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_ldata", 32'(audio_ldata), 32'h0);
        chk("reset_rdata", 32'(audio_rdata), 32'h0);
        chk("reset_valid", 32'(sample_valid), 32'h0);
        chk("reset_err", 32'(frame_err), 32'h0);
        rst = 1'b0;

        // Steady stream; each pair appears during bit 0 of the following frame
        send_frame(16'hA5C3, 16'h5A3C);
        send_frame(16'hA5C3, 16'h5A3C);
        chk("sync_no_valid", 32'(valid_cnt), 32'd0);
        send_frame(16'hA5C3, 16'h5A3C);
        chk("f3_valid_cnt", 32'(valid_cnt), 32'd1);
        chk("f3_ldata", 32'(audio_ldata), 32'hA5C3);
        chk("f3_rdata", 32'(audio_rdata), 32'h5A3C);
        send_frame(16'hA5C3, 16'h5A3C);
        chk("f4_valid_cnt", 32'(valid_cnt), 32'd2);
        chk("f4_interval", 32'(last_interval), 32'd256);
        send_frame(16'h0001, 16'h8000);
        chk("f5_valid_cnt", 32'(valid_cnt), 32'd3);
        chk("f5_no_err", 32'(err_cnt), 32'd0);
        send_frame(16'hFFFF, 16'h0000);
        chk("boundary_ldata", 32'(audio_ldata), 32'h0001);
        chk("boundary_rdata", 32'(audio_rdata), 32'h8000);
        send_frame(16'h0000, 16'hFFFF);
        chk("sweep1_ldata", 32'(audio_ldata), 32'hFFFF);
        chk("sweep1_rdata", 32'(audio_rdata), 32'h0000);
        send_frame(16'h1234, 16'h5678);
        chk("sweep2_ldata", 32'(audio_ldata), 32'h0000);
        chk("sweep2_rdata", 32'(audio_rdata), 32'hFFFF);
        chk("sweep_valid_cnt", 32'(valid_cnt), 32'd6);
        chk("sweep_interval", 32'(last_interval), 32'd256);

        // Left word cut to 12 BCLKs
        send_bits(1'b0, 16'h1111, 0, 11);
        send_bits(1'b1, 16'h2222, 0, DATA_W-1);
        chk("short_err_cnt", 32'(err_cnt), 32'd1);
        chk("short_valid_cnt", 32'(valid_cnt), 32'd7);
        send_frame(16'h9ABC, 16'hDEF0);
        chk("after_short_valid_cnt", 32'(valid_cnt), 32'd7);
        chk("after_short_ldata", 32'(audio_ldata), 32'h1234);
        chk("after_short_rdata", 32'(audio_rdata), 32'h5678);
        send_frame(16'h0F0F, 16'hF0F0);
        chk("recover_valid_cnt", 32'(valid_cnt), 32'd8);
        chk("recover_ldata", 32'(audio_ldata), 32'h9ABC);
        chk("recover_rdata", 32'(audio_rdata), 32'hDEF0);

        // BCLK stalled low for 1000 clk half-way through a left word
        send_bits(1'b0, 16'hAAAA, 0, 7);
        chk("pre_stall_valid_cnt", 32'(valid_cnt), 32'd9);
        audio_bclk = 1'b0;
        repeat (1000) @(negedge clk);
        chk("stall_valid_cnt", 32'(valid_cnt), 32'd9);
        chk("stall_err_cnt", 32'(err_cnt), 32'd1);
        chk("stall_ldata", 32'(audio_ldata), 32'h0F0F);
        chk("stall_rdata", 32'(audio_rdata), 32'hF0F0);
        send_bits(1'b0, 16'hAAAA, 8, DATA_W-1);
        send_bits(1'b1, 16'h5555, 0, DATA_W-1);
        send_frame(16'h3C3C, 16'hC3C3);
        chk("post_stall_ldata", 32'(audio_ldata), 32'hAAAA);
        chk("post_stall_rdata", 32'(audio_rdata), 32'h5555);
        chk("post_stall_err_cnt", 32'(err_cnt), 32'd1);

        // Reset for 3 clk in the middle of a right word
        send_bits(1'b0, 16'h1357, 0, DATA_W-1);
        send_bits(1'b1, 16'h2468, 0, 7);
        chk("pre_rst_valid_cnt", 32'(valid_cnt), 32'd11);
        chk("pre_rst_ldata", 32'(audio_ldata), 32'h3C3C);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ldata", 32'(audio_ldata), 32'h0);
        chk("rst_rdata", 32'(audio_rdata), 32'h0);
        rst = 1'b0;
        send_bits(1'b1, 16'h2468, 8, DATA_W-1);
        send_frame(16'h8000, 16'h7FFF);
        chk("post_rst_no_valid", 32'(valid_cnt), 32'd11);
        chk("post_rst_ldata_zero", 32'(audio_ldata), 32'h0);
        send_frame(16'h4321, 16'h8765);
        chk("post_rst_valid_cnt", 32'(valid_cnt), 32'd12);
        chk("post_rst_ldata", 32'(audio_ldata), 32'h8000);
        chk("post_rst_rdata", 32'(audio_rdata), 32'h7FFF);
        chk("post_rst_err_cnt", 32'(err_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
